serial_slave_burst_if: RTL and testbench

- Parametrised next-generation slave port for the serial system bus.
- Decodes a serial address frame, checks it against its device address, and moves one or more DATA_W-bit words between the serial w_data/r_data lines and a synchronous RAM.
- Adds over the previous slave: configurable widths, burst transfers with address auto-increment, and split retry with a grant timeout.
- Sits between the bus fabric (arbiter, tri-state enable) and one RAM.

---
 rtl/serial_slave_burst_if.sv | 243 ++++++++++++++++++++++++
 tb/tb_serial_slave_burst_if.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_burst_if.sv
// serial_slave_burst_if
//   Slave port for the serial system bus. Captures a start bit plus an
//   address frame {dev, rw, burst, mem_addr} MSB-first on addr. If dev matches
//   slave_address, it moves burst+1 DATA_W-bit words between the serial lines
//   and a synchronous RAM, auto-incrementing (and wrapping) the RAM address.
//   A busy target is answered with BUSY. The frame is parked in the single
//   split slot until the owning master is re-granted or the grant timeout
//   expires.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   addr, w_data      serial address / write-data lines in
//   r_data            serial read-data line out (holds last bit outside reads)
//   response          NAK=00 BUSY=01 OK=10 DONE=11
//   split_req         split retry request to the arbiter
//   split_master      master owning the pending split
//   granted_master    master currently granted the bus
//   slave_address     this device's address
//   slave_en          tri-state enable toward the bus
//   slave_busy        target busy
//   ram_*             synchronous RAM port (read data one cycle after address)
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_IDLE       | bus idle, waiting for a start bit on addr
// S_ADDR       | shifting in the FRAME_W-bit address frame
// S_DECODE     | device match / busy check, answer OK or BUSY
// S_WGAP       | one turnaround cycle before write data
// S_WDATA      | shifting in one write word from w_data
// S_WCOMMIT    | RAM write strobe, step to next word or finish
// S_RWAIT      | RAM read latency cycle
// S_RDATA      | shifting one read word out on r_data
// S_DONE       | DONE response for one cycle
// S_SPLIT      | frame parked, waiting for the target to go idle
// S_AWAIT_GRANT| split_req raised, waiting for the split master's grant
module serial_slave_burst_if #(
  parameter int DATA_W        = 8,
  parameter int MEM_AW        = 12,
  parameter int DEV_BITS      = 2,
  parameter int BURST_BITS    = 2,
  parameter int MID_W         = 2,
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                addr,
  input  logic                w_data,
  output logic                r_data,
  output logic [1:0]          response,
  output logic                split_req,
  output logic [MID_W-1:0]    split_master,
  input  logic [MID_W-1:0]    granted_master,
  input  logic [DEV_BITS-1:0] slave_address,
  output logic                slave_en,
  input  logic                slave_busy,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [MEM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we
);

  localparam int FRAME_W = DEV_BITS + 1 + BURST_BITS + MEM_AW;
  localparam int CNT_MAX = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = (SPLIT_TIMEOUT > 1) ? $clog2(SPLIT_TIMEOUT + 1) : 1;

  localparam logic [1:0] RSP_NAK  = 2'b00;
  localparam logic [1:0] RSP_BUSY = 2'b01;
  localparam logic [1:0] RSP_OK   = 2'b10;
  localparam logic [1:0] RSP_DONE = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DECODE, S_WGAP, S_WDATA, S_WCOMMIT,
    S_RWAIT, S_RDATA, S_DONE, S_SPLIT, S_AWAIT_GRANT
  } state_t;

  state_t state, state_nxt;

  // frame_sr doubles as the split slot: nothing shifts into it while a
  // split is pending, so the parked frame is replayed straight into DECODE.
  logic [FRAME_W-1:0]    frame_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_W-1:0]     wd_sr;
  logic [BURST_BITS-1:0] words_left;
  logic [TO_W-1:0]       to_cnt;
  logic                  r_hold;
  logic                  r_sel;

  logic [DEV_BITS-1:0]   f_dev;
  logic                  f_write;
  logic [BURST_BITS-1:0] f_burst;
  logic [MEM_AW-1:0]     f_mem_addr;
  logic                  dev_match;
  logic                  last_bit;
  logic                  granted;
  logic                  timed_out;

  assign f_dev      = frame_sr[FRAME_W-1 -: DEV_BITS];
  assign f_write    = frame_sr[MEM_AW + BURST_BITS];
  assign f_burst    = frame_sr[MEM_AW +: BURST_BITS];
  assign f_mem_addr = frame_sr[MEM_AW-1:0];
  assign dev_match  = (f_dev == slave_address);
  assign last_bit   = (bit_cnt == CNT_W'(1));
  assign granted    = (granted_master == split_master);
  assign timed_out  = (SPLIT_TIMEOUT != 0) && (to_cnt == TO_W'(1));
  assign ram_wdata  = wd_sr;

  // bit_cnt counts DATA_W..1 during RDATA, so bit (bit_cnt-1) goes out MSB first
  always_comb begin
    r_sel = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_cnt == CNT_W'(i + 1)) r_sel = ram_rdata[i];
    end
  end

  always_comb begin
    state_nxt = state;
    response  = RSP_NAK;
    slave_en  = 1'b0;
    ram_we    = 1'b0;
    split_req = 1'b0;
    r_data    = r_hold;
    case (state)
      S_IDLE:    if (addr) state_nxt = S_ADDR;
      S_ADDR:    if (last_bit) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!dev_match) begin
          state_nxt = S_IDLE;
        end else begin
          slave_en = 1'b1;
          if (slave_busy) begin
            response  = RSP_BUSY;
            state_nxt = S_SPLIT;
          end else begin
            response  = RSP_OK;
            state_nxt = f_write ? S_WGAP : S_RWAIT;
          end
        end
      end
      S_WGAP: begin
        slave_en  = 1'b1;
        state_nxt = S_WDATA;
      end
      S_WDATA: begin
        slave_en = 1'b1;
        if (last_bit) state_nxt = S_WCOMMIT;
      end
      S_WCOMMIT: begin
        slave_en  = 1'b1;
        // a synchronous reset in this cycle must not let the write through
        ram_we    = !reset;
        state_nxt = (words_left != '0) ? S_WDATA : S_DONE;
      end
      S_RWAIT: begin
        slave_en  = 1'b1;
        state_nxt = S_RDATA;
      end
      S_RDATA: begin
        slave_en = 1'b1;
        r_data   = r_sel;
        if (last_bit) state_nxt = (words_left != '0) ? S_RWAIT : S_DONE;
      end
      S_DONE: begin
        slave_en  = 1'b1;
        response  = RSP_DONE;
        state_nxt = S_IDLE;
      end
      S_SPLIT:   if (!slave_busy) state_nxt = S_AWAIT_GRANT;
      S_AWAIT_GRANT: begin
        split_req = 1'b1;
        // grant takes priority over a timeout in the same cycle
        if (granted)        state_nxt = S_DECODE;
        else if (timed_out) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      frame_sr     <= '0;
      bit_cnt      <= '0;
      wd_sr        <= '0;
      words_left   <= '0;
      to_cnt       <= '0;
      r_hold       <= 1'b0;
      ram_addr     <= '0;
      split_master <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: bit_cnt <= CNT_W'(FRAME_W);
        S_ADDR: begin
          frame_sr <= {frame_sr[FRAME_W-2:0], addr};
          bit_cnt  <= bit_cnt - CNT_W'(1);
        end
        S_DECODE: begin
          if (dev_match) begin
            if (slave_busy) begin
              split_master <= granted_master;
            end else begin
              ram_addr   <= f_mem_addr;
              words_left <= f_burst;
            end
          end
        end
        S_WGAP: bit_cnt <= CNT_W'(DATA_W);
        S_WDATA: begin
          wd_sr   <= {wd_sr[DATA_W-2:0], w_data};
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        S_WCOMMIT: begin
          bit_cnt <= CNT_W'(DATA_W);
          if (words_left != '0) begin
            words_left <= words_left - BURST_BITS'(1);
            ram_addr   <= ram_addr + MEM_AW'(1);
          end
        end
        S_RWAIT: bit_cnt <= CNT_W'(DATA_W);
        S_RDATA: begin
          r_hold  <= r_sel;
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (last_bit && (words_left != '0)) begin
            words_left <= words_left - BURST_BITS'(1);
            ram_addr   <= ram_addr + MEM_AW'(1);
          end
        end
        S_SPLIT: to_cnt <= TO_W'(SPLIT_TIMEOUT);
        S_AWAIT_GRANT: begin
          if (!granted) begin
            if (timed_out)                to_cnt <= to_cnt;
            else if (to_cnt > TO_W'(1))   to_cnt <= to_cnt - TO_W'(1);
            // timeout frees the split slot
            if (timed_out) split_master <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_burst_if.sv
// Scoreboard bench for serial_slave_burst_if: stimulus pushes expected
// events (responses, RAM writes, read words, split requests) into a queue,
// and an independent monitor pops and compares them as the DUT shows them.
module tb_serial_slave_burst_if;
  localparam int DATA_W = 8, MEM_AW = 12, DEV_BITS = 2, BURST_BITS = 2, MID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, addr, w_data, r_data, split_req, slave_en, slave_busy, ram_we;
  logic [1:0]          response;
  logic [MID_W-1:0]    split_master, granted_master;
  logic [DEV_BITS-1:0] slave_address;
  logic [DATA_W-1:0]   ram_rdata, ram_wdata;
  logic [MEM_AW-1:0]   ram_addr;

  serial_slave_burst_if #(
    .DATA_W(DATA_W), .MEM_AW(MEM_AW), .DEV_BITS(DEV_BITS),
    .BURST_BITS(BURST_BITS), .MID_W(MID_W), .SPLIT_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .w_data(w_data), .r_data(r_data),
    .response(response), .split_req(split_req), .split_master(split_master),
    .granted_master(granted_master), .slave_address(slave_address),
    .slave_en(slave_en), .slave_busy(slave_busy), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
  );

  // bench RAM with a preload port
  logic [7:0]  ram [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // reference memory contents as the model sees them
  logic [7:0] ref_mem [0:4095];
  logic [7:0] wbuf [0:3];

  typedef enum int {K_RESP, K_WR, K_RDW, K_SREQ} kind_t;
  typedef struct {kind_t kind; int a; int b;} item_t;
  item_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(kind_t k, int a, int b);
    item_t it;
    it.kind = k; it.a = a; it.b = b;
    exp_q.push_back(it);
  endfunction

  function automatic bit pop(string name, output item_t it);
    it.kind = K_RESP; it.a = -1; it.b = 0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected DUT event, got event, expected none", name);
      return 1'b0;
    end
    it = exp_q.pop_front();
    return 1'b1;
  endfunction

  // monitor
  initial begin : monitor
    logic       prev_sreq;
    item_t      it, it2;
    logic [7:0] w;
    prev_sreq = 1'b0;
    w = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sreq = 1'b0;
      end else begin
        if (ram_we) begin
          if (pop("wr_event", it)) begin
            check("wr_kind", int'(it.kind), int'(K_WR));
            check("wr_addr", int'(ram_addr), it.a);
            check("wr_data", int'(ram_wdata), it.b);
          end
        end
        if (split_req && !prev_sreq) begin
          if (pop("sreq_event", it)) begin
            check("sreq_kind", int'(it.kind), int'(K_SREQ));
            check("split_master", int'(split_master), it.a);
          end
        end
        prev_sreq = split_req;
        if (response != 2'b00) begin
          if (pop("resp_event", it)) begin
            check("resp_kind", int'(it.kind), int'(K_RESP));
            check("response", int'(response), it.a);
            if (it.kind == K_RESP && it.a == 2 && it.b > 0) begin
              for (int k = 0; k < it.b; k++) begin
                @(negedge clk);
                for (int j = DATA_W - 1; j >= 0; j--) begin
                  @(negedge clk);
                  w[j] = r_data;
                end
                if (pop("rd_event", it2)) begin
                  check("rd_kind", int'(it2.kind), int'(K_RDW));
                  check("rd_word", int'(w), it2.a);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // start bit + frame; returns at the negedge inside the DECODE cycle
  task automatic send_frame(input logic [1:0] dev, input logic wr,
                            input logic [1:0] burst, input logic [11:0] a);
    logic [16:0] f;
    f = {dev, wr, burst, a};
    @(negedge clk); addr = 1'b1;
    for (int i = 16; i >= 0; i--) begin
      @(negedge clk); addr = f[i];
    end
    @(negedge clk); addr = 1'b0;
  endtask

  // called at the negedge of the DECODE cycle that answered OK
  task automatic drive_words(input int n);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int j = 7; j >= 0; j--) begin
        @(negedge clk); w_data = wbuf[k][j];
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(input logic [1:0] code, input int bound, input string name);
    int k;
    k = 0;
    while (response !== code && k < bound) begin
      @(negedge clk); k++;
    end
    if (response !== code) check(name, int'(response), int'(code));
  endtask

  task automatic wait_sreq(input int bound);
    int k;
    k = 0;
    while (!split_req && k < bound) begin
      @(negedge clk); k++;
    end
    if (!split_req) check("sreq_wait", int'(split_req), 1);
  endtask

  task automatic do_txn(input logic [1:0] dev, input logic wr,
                        input logic [1:0] burst, input logic [11:0] a);
    int n;
    logic [11:0] wa;
    n = int'(burst) + 1;
    if (dev != slave_address) begin
      send_frame(dev, wr, burst, a);
      check("nomatch_en", int'(slave_en), 0);
      check("nomatch_resp", int'(response), 0);
      @(negedge clk);
      check("nomatch_idle_en", int'(slave_en), 0);
      return;
    end
    push(K_RESP, 2, wr ? 0 : n);
    for (int i = 0; i < n; i++) begin
      wa = a + 12'(i);
      if (wr) begin
        push(K_WR, int'(wa), int'(wbuf[i]));
        ref_mem[wa] = wbuf[i];
      end else begin
        push(K_RDW, int'(ref_mem[wa]), 0);
      end
    end
    push(K_RESP, 3, 0);
    send_frame(dev, wr, burst, a);
    if (wr) drive_words(n);
    wait_resp(2'b11, 80, "done_wait");
    @(negedge clk);
    check("done_one_cycle", int'(response), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_response"}, int'(response), 0);
    check({tag, "_slave_en"}, int'(slave_en), 0);
    check({tag, "_split_req"}, int'(split_req), 0);
    check({tag, "_split_master"}, int'(split_master), 0);
    check({tag, "_ram_we"}, int'(ram_we), 0);
    check({tag, "_ram_addr"}, int'(ram_addr), 0);
    check({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    check({tag, "_r_data"}, int'(r_data), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n;
    logic [1:0]  dv;
    logic [11:0] a;
    reset = 1'b1; addr = 1'b0; w_data = 1'b0; slave_busy = 1'b0;
    granted_master = '0; slave_address = 2'b01;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clk);
    for (int i = 0; i < 4096; i++) preload(i[11:0], 8'($urandom));
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // single write
    wbuf[0] = 8'hC3;
    do_txn(2'b01, 1'b1, 2'd0, 12'h0A5);

    // burst read across the address wrap
    preload(12'hFFE, 8'h11); preload(12'hFFF, 8'h22);
    preload(12'h000, 8'h33); preload(12'h001, 8'h44);
    do_txn(2'b01, 1'b0, 2'd3, 12'hFFE);

    // address mismatch
    do_txn(2'b10, 1'b1, 2'd0, 12'h055);

    // busy split, regranted to master 2, two-word write
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    push(K_RESP, 1, 0);
    push(K_SREQ, 2, 0);
    push(K_RESP, 2, 0);
    push(K_WR, 12'h300, int'(wbuf[0])); ref_mem[12'h300] = wbuf[0];
    push(K_WR, 12'h301, int'(wbuf[1])); ref_mem[12'h301] = wbuf[1];
    push(K_RESP, 3, 0);
    granted_master = 2'd2; slave_busy = 1'b1;
    send_frame(2'b01, 1'b1, 2'd1, 12'h300);
    @(negedge clk); granted_master = 2'd0;
    repeat (4) @(negedge clk);
    slave_busy = 1'b0;
    wait_sreq(20);
    @(negedge clk); granted_master = 2'd2;
    wait_resp(2'b10, 20, "regrant_wait");
    drive_words(2);
    wait_resp(2'b11, 80, "split_done_wait");
    @(negedge clk); granted_master = 2'd0;

    // split timeout, grant never given
    push(K_RESP, 1, 0);
    push(K_SREQ, 1, 0);
    granted_master = 2'd1; slave_busy = 1'b1;
    send_frame(2'b01, 1'b0, 2'd0, 12'h123);
    @(negedge clk); granted_master = 2'd3; slave_busy = 1'b0;
    wait_sreq(20);
    n = 0;
    while (split_req && n < 20) begin
      n++; @(negedge clk);
    end
    check("timeout_len", n, 4);
    check("timeout_resp", int'(response), 0);
    check("timeout_slot_freed", int'(split_master), 0);
    granted_master = 2'd0;
    wbuf[0] = 8'($urandom);
    do_txn(2'b01, 1'b1, 2'd0, 12'h124);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      dv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      a = 12'($urandom);
      if ($urandom_range(0, 3) == 0) a = 12'hFFD + 12'($urandom_range(0, 2));
      do_txn(dv, 1'($urandom), 2'($urandom), a);
    end

    // reset after the second WCOMMIT of a four-word write
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    push(K_RESP, 2, 0);
    push(K_WR, 12'h7F0, int'(wbuf[0])); ref_mem[12'h7F0] = wbuf[0];
    push(K_WR, 12'h7F1, int'(wbuf[1])); ref_mem[12'h7F1] = wbuf[1];
    send_frame(2'b01, 1'b1, 2'd3, 12'h7F0);
    drive_words(2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_all_zero("midburst");
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); w_data = 1'($urandom);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
